// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with a sequenced clear FSM.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle IDLE write data to read ports.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clr_req,
    output logic                     clr_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr0, wr1;

    assign clr_busy = state_q == CLEAR;
    assign wr0 = we0 && !reset && state_q == IDLE && !(ZERO_REG != 0 && waddr0 == '0);
    assign wr1 = we1 && !reset && state_q == IDLE && !(ZERO_REG != 0 && waddr1 == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (reset) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == '1) ? IDLE : CLEAR;
        end else if (clr_req) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clock) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr0) mem_q[waddr0] <= wdata0;
            if (wr1) mem_q[waddr1] <= wdata1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        assign ra = raddr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign rv = (wr1 && waddr1 == ra) ? wdata1 :
                    (wr0 && waddr0 == ra) ? wdata0 : mem_q[ra];
`else
        assign rv = mem_q[ra];
`endif
        assign rdata[k*DATA_W +: DATA_W] =
            (state_q == CLEAR || (ZERO_REG != 0 && ra == '0)) ? '0 : rv;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against a behavioural model.
module tb_regfile_mp;
    logic        clock = 1'b0;
    logic        reset, clr_req, clr_busy;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr;
    logic [63:0] rdata;

    int checks = 0;
    int errors = 0;
    int busy_left;
    logic [31:0] mem_m [32];
    logic busy_seen;

    regfile_mp dut (
        .clock(clock), .reset(reset), .clr_req(clr_req), .clr_busy(clr_busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (busy_left > 0 || ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (!reset && we1 && waddr1 == ra) return wdata1;
        if (!reset && we0 && waddr0 == ra) return wdata0;
`endif
        return mem_m[ra];
    endfunction

    // A clear occupies 32 cycles and leaves every entry zero when it finishes.
    task automatic model_edge();
        if (reset) begin
            busy_left = 32;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
        end else begin
            if (we0 && waddr0 != 5'd0) mem_m[waddr0] = wdata0;
            if (we1 && waddr1 != 5'd0) mem_m[waddr1] = wdata1;
            if (clr_req) busy_left = 32;
        end
    endtask

    task automatic step();
        #4;
        busy_seen = clr_busy;
        check("busy", {63'h0, clr_busy}, {63'h0, busy_left > 0});
        for (int k = 0; k < 2; k++)
            check($sformatf("rd%0d", k), {32'h0, rdata[k*32 +: 32]}, {32'h0, exp_rd(raddr[k*5 +: 5])});
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_in();
        clr_req = 0; we0 = 0; we1 = 0;
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        repeat (40) begin
            step();
            if (busy_seen) n++;
        end
        check(tag, n, 32);
    endtask

    initial begin
        logic [31:0] old5;
        idle_in();
        raddr = 0;
        reset = 1;
        busy_left = 32;
        @(posedge clock);
        model_edge();
        #1;
        step();
        reset = 0;
        count_busy("reset_clr_len");
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(31 - a)};
            step();
        end

        we0 = 1; waddr0 = 3; wdata0 = 32'hDEADBEEF;
        step();
        idle_in();
        raddr = {5'd0, 5'd3};
        #1;
        check("deadbeef", {32'h0, rdata[31:0]}, 64'hDEADBEEF);
        step();

        we0 = 1; waddr0 = 7; wdata0 = 32'h11;
        we1 = 1; waddr1 = 7; wdata1 = 32'h22;
        step();
        we0 = 1; waddr0 = 0; wdata0 = 32'h55; we1 = 0;
        step();
        idle_in();
        raddr = {5'd0, 5'd7};
        #1;
        check("collide7", {32'h0, rdata[31:0]}, 64'h22);
        check("zero_reg", {32'h0, rdata[63:32]}, 64'h0);
        step();

        old5 = mem_m[5];
        we0 = 1; waddr0 = 5; wdata0 = 32'hA5A5A5A5;
        raddr = {5'd5, 5'd0};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass5", {32'h0, rdata[63:32]}, 64'hA5A5A5A5);
`else
        check("nobypass5", {32'h0, rdata[63:32]}, {32'h0, old5});
`endif
        step();
        idle_in();

        clr_req = 1;
        step();
        clr_req = 0;
        repeat (10) step();
        clr_req = 1;
        step();
        clr_req = 0;
        repeat (9) step();
        reset = 1;
        step();
        reset = 0;
        count_busy("rst_mid_clr_len");

        we0 = 1; waddr0 = 9; wdata0 = 32'h1234;
        step();
        clr_req = 1; we0 = 0;
        step();
        clr_req = 0; we0 = 1; wdata0 = 32'h1234;
        repeat (5) step();
        idle_in();
        repeat (30) step();
        raddr = {5'd9, 5'd9};
        #1;
        check("clr_wr_ignored", {32'h0, rdata[31:0]}, 64'h0);
        step();

        repeat (3000) begin
            reset   = ($urandom_range(0, 299) == 0);
            clr_req = ($urandom_range(0, 59) == 0);
            we0 = $urandom_range(0, 1); waddr0 = 5'($urandom); wdata0 = $urandom;
            we1 = $urandom_range(0, 1); waddr1 = 5'($urandom); wdata1 = $urandom;
            if ($urandom_range(0, 3) == 0) waddr1 = waddr0;
            raddr = 10'($urandom);
            if ($urandom_range(0, 2) == 0) raddr[4:0] = waddr0;
            if ($urandom_range(0, 2) == 0) raddr[9:5] = waddr1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
